// File: rtl/mux_nne1_reg.sv
// mux_nne1_reg -- registered N-to-1 word multiplexer with valid/ready handshake.
//
// Selects one of NUM_INPUTS channels of WIDTH bits and registers the result.
// The select is either the external S (Mode=0) or an internal round-robin scan
// counter (Mode=1) that advances on every accepted word taken in scan mode.
// A select beyond the last channel still completes a transfer, returning zero
// with Gabim set.
//
// Build option: define MUXNNE1_SKID_EN to add a one-entry skid register behind
// the output stage. HyrjaReady then comes straight from a flop ("skid empty"),
// so there is no combinational path from RezReady to HyrjaReady. Without the
// macro, HyrjaReady = !RezValid || RezReady.
//
// Ports:
//   Clock       in   rising-edge clock
//   Reset       in   synchronous, active-high reset
//   Hyrja       in   NUM_INPUTS*WIDTH flattened channels, channel k at [k*WIDTH +: WIDTH]
//   S           in   SEL_W external channel select (Mode=0)
//   Mode        in   0 = external select, 1 = auto-scan
//   HyrjaValid  in   input word/select valid
//   HyrjaReady  out  block accepts this cycle
//   Rez         out  WIDTH registered selected word
//   RezValid    out  Rez holds an unconsumed result
//   RezReady    in   downstream consumes Rez this cycle
//   RezKanali   out  SEL_W channel index that produced Rez
//   Gabim       out  Rez came from an out-of-range select
module mux_nne1_reg #(
  parameter int WIDTH      = 16,
  parameter int NUM_INPUTS = 6,
  parameter int SEL_W      = 3
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [NUM_INPUTS*WIDTH-1:0] Hyrja,
  input  logic [SEL_W-1:0]            S,
  input  logic                        Mode,
  input  logic                        HyrjaValid,
  output logic                        HyrjaReady,
  output logic [WIDTH-1:0]            Rez,
  output logic                        RezValid,
  input  logic                        RezReady,
  output logic [SEL_W-1:0]            RezKanali,
  output logic                        Gabim
);

  logic [SEL_W-1:0] r_cnt;
  logic [SEL_W-1:0] w_cnt_nxt;
  logic [SEL_W-1:0] w_sel_p0;
  logic [WIDTH-1:0] w_word_p0;
  logic             w_oor_p0;
  logic             w_acc;
  logic             w_pop;

  logic [WIDTH-1:0] r_rez_p1;
  logic [SEL_W-1:0] r_kan_p1;
  logic             r_gab_p1;
  logic             r_vld_p1;

  // Stage p0: select resolution and channel mux
  assign w_sel_p0 = Mode ? r_cnt : S;
  assign w_oor_p0 = (32'(w_sel_p0) >= NUM_INPUTS);

  // Only legal channels are scanned, so an out-of-range select yields zero.
  always_comb begin
    w_word_p0 = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (w_sel_p0 == SEL_W'(k)) w_word_p0 = Hyrja[k*WIDTH +: WIDTH];
    end
  end

  // Scan counter wraps at the last legal channel so scan mode never errors.
  assign w_cnt_nxt = (r_cnt == SEL_W'(NUM_INPUTS - 1)) ? '0 : r_cnt + 1'b1;

  assign w_acc = HyrjaValid && HyrjaReady;
  assign w_pop = r_vld_p1 && RezReady;

`ifdef MUXNNE1_SKID_EN
  logic [WIDTH-1:0] r_skid_rez;
  logic [SEL_W-1:0] r_skid_kan;
  logic             r_skid_gab;
  logic             r_skid_vld;

  assign HyrjaReady = !r_skid_vld;

  // Stage p1: output register with skid behind it
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rez_p1   <= '0;
      r_kan_p1   <= '0;
      r_gab_p1   <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_skid_rez <= '0;
      r_skid_kan <= '0;
      r_skid_gab <= 1'b0;
      r_skid_vld <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (r_skid_vld) begin
        // Input is blocked while the skid is full; drain it in order on pop.
        if (w_pop) begin
          r_rez_p1   <= r_skid_rez;
          r_kan_p1   <= r_skid_kan;
          r_gab_p1   <= r_skid_gab;
          r_skid_vld <= 1'b0;
        end
      end else if (w_acc) begin
        if (!r_vld_p1 || RezReady) begin
          r_rez_p1 <= w_word_p0;
          r_kan_p1 <= w_sel_p0;
          r_gab_p1 <= w_oor_p0;
          r_vld_p1 <= 1'b1;
        end else begin
          r_skid_rez <= w_word_p0;
          r_skid_kan <= w_sel_p0;
          r_skid_gab <= w_oor_p0;
          r_skid_vld <= 1'b1;
        end
      end else if (w_pop) begin
        r_vld_p1 <= 1'b0;
      end
      if (w_acc && Mode) r_cnt <= w_cnt_nxt;
    end
  end
`else
  assign HyrjaReady = !r_vld_p1 || RezReady;

  // Stage p1: output register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rez_p1 <= '0;
      r_kan_p1 <= '0;
      r_gab_p1 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_cnt    <= '0;
    end else begin
      // Accept has priority over pop: a same-cycle pop+accept keeps valid high.
      if (w_acc) begin
        r_rez_p1 <= w_word_p0;
        r_kan_p1 <= w_sel_p0;
        r_gab_p1 <= w_oor_p0;
        r_vld_p1 <= 1'b1;
      end else if (w_pop) begin
        r_vld_p1 <= 1'b0;
      end
      if (w_acc && Mode) r_cnt <= w_cnt_nxt;
    end
  end
`endif

  assign Rez       = r_rez_p1;
  assign RezValid  = r_vld_p1;
  assign RezKanali = r_kan_p1;
  assign Gabim     = r_gab_p1;

endmodule

// File: doc/mux_nne1_reg.md
Name: mux_nne1_reg

Overview:
- Parametrised, registered N-to-1 word multiplexer.
- Generalises the 6-to-1 single-bit select mux to NUM_INPUTS channels of WIDTH bits each.
- Adds a valid/ready handshake, a registered output stage, an auto-scan (round-robin) select mode and out-of-range select detection.
- Sits between the register-file/ALU result buses and the CPU writeback/bus path, where selection must be pipelined and back-pressurable.

Parameters:
- WIDTH, 16, bit width of each input channel and of Rez.
- NUM_INPUTS, 6, number of input channels; legal range 2..16.
- SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_INPUTS.

Ports:
- Clock  input  1  single clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Hyrja  input  NUM_INPUTS*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
- S  input  SEL_W  channel select, used when Mode=0.
- Mode  input  1  0 = external select S; 1 = auto-scan using the internal counter.
- HyrjaValid  input  1  the input word/select is valid this cycle.
- HyrjaReady  output  1  the block accepts this cycle.
- Rez  output  WIDTH  registered selected word.
- RezValid  output  1  Rez holds an unconsumed result.
- RezReady  input  1  downstream consumes Rez this cycle.
- RezKanali  output  SEL_W  channel index that produced the current Rez.
- Gabim  output  1  current Rez came from an out-of-range select.

Behaviour:
- Interface: one clock (Clock); reset is synchronous and active-high (Reset).
- Reset values:
  - Rez=0, RezValid=0, RezKanali=0, Gabim=0.
  - Scan counter Numeruesi=0.
  - HyrjaReady=1 in the cycle after reset deasserts.
- Accept condition: acc = HyrjaValid && HyrjaReady.
- Pop condition: pop = RezValid && RezReady.
- Base build: HyrjaReady = !RezValid || RezReady. This is combinational from RezReady and is allowed only in the base build.
- Effective select: sel = Mode ? Numeruesi : S.
- On acc:
  - Rez <= channel[sel] if sel < NUM_INPUTS, else 0.
  - Gabim <= (sel >= NUM_INPUTS).
  - RezKanali <= sel.
  - RezValid <= 1.
- Latency: exactly 1 cycle from acc to RezValid=1. Throughput is 1 word/cycle while RezReady=1.
- Pop without acc: RezValid <= 0. Rez, RezKanali and Gabim hold their values.
- Simultaneous pop and acc: the new word replaces the old one; RezValid stays 1; no bubble.
- Back-pressure: while RezValid=1 and RezReady=0, all output registers hold and HyrjaReady=0.
- Scan counter:
  - Increments only on acc with Mode=1.
  - Wraps from NUM_INPUTS-1 to 0; it never takes an out-of-range value, so Gabim is always 0 in scan mode.
  - Holds while Mode=0.
  - Changing Mode mid-stream takes effect on the next acc; the counter is not cleared.
- Out-of-range S (possible when NUM_INPUTS < 2**SEL_W, e.g. S=6 or 7 at defaults): the transfer still completes with Rez=0 and Gabim=1.
- Reset mid-operation: any held Rez is dropped; RezValid=0 in the following cycle; Numeruesi=0.
- Hyrja and S are sampled only on acc; their values at other times are don't-care.

Optional Feature:
- Macro: MUXNNE1_SKID_EN.
- Defined:
  - A 1-entry skid register is added behind the output register.
  - HyrjaReady becomes a registered signal, equal to "skid empty".
  - If acc occurs while the output is stalled, the word goes into the skid register. It moves to the output on the next pop, in order.
  - Latency stays 1 cycle; no input-to-output combinational path remains; full throughput is kept.
  - Reset clears the skid register.
- Undefined: base behaviour above, with no skid storage.

Test Plan:
- Reset, then Mode=0, S=3, Hyrja channel3=16'hA5A5, HyrjaValid=1, RezReady=1 -> next cycle Rez=16'hA5A5, RezValid=1, RezKanali=3, Gabim=0.
- Mode=0, S=7 at NUM_INPUTS=6 -> Rez=16'h0000, Gabim=1, RezKanali=7, RezValid=1.
- Mode=1, channels k=16'h0100+k, 8 back-to-back accepts with RezReady=1 -> Rez sequence 0100,0101,0102,0103,0104,0105,0100,0101 (counter wraps 5->0); Gabim stays 0.
- Accept word 16'h1111, hold RezReady=0 for 3 cycles with HyrjaValid=1 -> Rez holds 16'h1111, HyrjaReady=0 (base build); then RezReady=1 -> pop and new accept in the same cycle, RezValid stays 1.
- Reset asserted while RezValid=1 and Numeruesi=4 -> next cycle RezValid=0, Rez=0, Numeruesi=0; the first scan-mode accept then selects channel 0.
- With MUXNNE1_SKID_EN: stall the output holding 16'h2222 and accept 16'h3333 -> HyrjaReady drops to 0 next cycle; after release, Rez outputs 16'h2222 then 16'h3333, in order, with no loss.
